// File: rtl/prio_enc_pipe.sv
// rtl/prio_enc_pipe.sv - pipelined fixed/round-robin priority encoder with valid/ready handshake
// Optional output handshake counters are enabled by defining PRIO_ENC_STATS_EN.
module prio_enc_pipe #(
  parameter int WIDTH  = 128,
  parameter int IDX_W  = $clog2(WIDTH),
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rr_mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_any
`ifdef PRIO_ENC_STATS_EN
  ,
  output logic [31:0]      stat_grants,
  output logic [31:0]      stat_empty
`endif
);

  logic             advance;
  logic             accept;
  logic [IDX_W-1:0] hi_all;
  logic [IDX_W-1:0] hi_below;
  logic             any_all;
  logic             any_below;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] any_q;
  logic [IDX_W-1:0]  idx_q [STAGES];

  // Ascending scan: the last hit is the highest set index, overall and below ptr.
  always_comb begin
    hi_all    = '0;
    hi_below  = '0;
    any_all   = 1'b0;
    any_below = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (in_req[i]) begin
        hi_all  = IDX_W'(i);
        any_all = 1'b1;
        if (IDX_W'(i) < ptr_q) begin
          hi_below  = IDX_W'(i);
          any_below = 1'b1;
        end
      end
    end
  end

  always_comb begin
    grant_idx = (rr_mode && any_below) ? hi_below : hi_all;
    advance   = ~out_valid | out_ready;
    in_ready  = advance;
    accept    = in_valid & advance;
    ptr_d     = (accept && rr_mode && any_all) ? grant_idx : ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      any_q   <= '0;
      ptr_q   <= '0;
      for (int k = 0; k < STAGES; k++) idx_q[k] <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (advance) begin
        valid_q[0] <= accept;
        any_q[0]   <= accept & any_all;
        idx_q[0]   <= accept ? grant_idx : '0;
        for (int k = 1; k < STAGES; k++) begin
          valid_q[k] <= valid_q[k-1];
          any_q[k]   <= any_q[k-1];
          idx_q[k]   <= idx_q[k-1];
        end
      end
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign out_any   = any_q[STAGES-1];
  assign out_idx   = idx_q[STAGES-1];

`ifdef PRIO_ENC_STATS_EN
  logic        out_hs;
  logic [31:0] grants_q;
  logic [31:0] grants_d;
  logic [31:0] empty_q;
  logic [31:0] empty_d;

  always_comb begin
    out_hs   = out_valid & out_ready;
    grants_d = grants_q;
    empty_d  = empty_q;
    if (out_hs && out_any && grants_q != 32'hFFFF_FFFF) grants_d = grants_q + 32'd1;
    if (out_hs && !out_any && empty_q != 32'hFFFF_FFFF) empty_d = empty_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grants_q <= '0;
      empty_q  <= '0;
    end else begin
      grants_q <= grants_d;
      empty_q  <= empty_d;
    end
  end

  assign stat_grants = grants_q;
  assign stat_empty  = empty_q;
`endif

endmodule
